// File: rtl/regfile_pkg.sv
// Shared defaults, address type and sizing helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;

    // Ceiling log2, usable in parameter defaults.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int unsigned ADDR_W_DEF = clog2_f(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (IDLE/PENDING) with issue handshake; an accepted issue
// outranks a same-cycle writeback clear because the new producer owns the register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ADDR_W   = clog2_f(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     iss_ready,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [NUM_REGS-1:0] busy_d, busy_q;
    logic [NUM_REGS-1:0] clr_vec;
    logic                iss_fire;

    // Readiness comes from registered state only; a same-cycle clear does not help.
    assign iss_ready = ~busy_q[iss_rd] | (iss_rd == '0);
    assign iss_fire  = iss_valid & iss_ready;
    assign busy_vec  = busy_q;

    always_comb begin
        clr_vec = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_clr[p]) begin
                clr_vec[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with x0 hardwired to zero and a busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ADDR_W   = clog2_f(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     iss_ready,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec)
    );

    // Ascending port order lets the highest-index writer win a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
            rd_busy[k]                  = busy_vec[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])
                    && (rd_addr[k*ADDR_W +: ADDR_W] != '0)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
                    rd_busy[k] = busy_vec[rd_addr[k*ADDR_W +: ADDR_W]] & ~wr_clr[p];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and random checks of regfile_mp_sb: a default instance and a
// 16-reg / 4-read / 1-write / 64-bit instance, each against its own array model.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: defaults (32 regs, 32-bit, 2R/2W)
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en, a_wr_clr;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_iss_valid, a_iss_ready;
    logic [4:0]  a_iss_rd;
    logic [31:0] a_busy_vec;

    // Instance B: 16 regs, 64-bit, 4R/1W
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [0:0]   b_wr_en, b_wr_clr;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_iss_valid, b_iss_ready;
    logic [3:0]   b_iss_rd;
    logic [15:0]  b_busy_vec;

    regfile_mp_sb dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (a_rd_addr),
        .rd_data   (a_rd_data),
        .rd_busy   (a_rd_busy),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .wr_clr    (a_wr_clr),
        .iss_valid (a_iss_valid),
        .iss_rd    (a_iss_rd),
        .iss_ready (a_iss_ready),
        .busy_vec  (a_busy_vec)
    );

    regfile_mp_sb #(
        .DATA_W   (64),
        .NUM_REGS (16),
        .NUM_RD   (4),
        .NUM_WR   (1)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_busy   (b_rd_busy),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .wr_clr    (b_wr_clr),
        .iss_valid (b_iss_valid),
        .iss_rd    (b_iss_rd),
        .iss_ready (b_iss_ready),
        .busy_vec  (b_busy_vec)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, an array of register values and busy flags
    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];
    bit          acc    [2];
    int          nrd [2], nwr [2], nreg [2];

    // Generic per-instance stimulus, mapped onto the DUT ports by drive()
    logic        s_iv    [2];
    logic [4:0]  s_ird   [2];
    logic        s_wen   [2][2];
    logic        s_wclr  [2][2];
    logic [4:0]  s_waddr [2][2];
    logic [63:0] s_wdata [2][2];
    logic [4:0]  s_raddr [2][4];

    task automatic a_idle();
        a_wr_en = '0; a_wr_clr = '0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_valid = 1'b0; a_iss_rd = '0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] addr, input logic [31:0] data,
                        input logic clr);
        a_wr_en[p] = 1'b1;
        a_wr_clr[p] = clr;
        a_wr_addr[p*5 +: 5] = addr;
        a_wr_data[p*32 +: 32] = data;
    endtask

    function automatic logic [4:0] pick(input int i);
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, nreg[i] - 1));
    endfunction

    task automatic gen(input int i);
        // A refused issue is held unchanged until it is accepted.
        if (!(s_iv[i] && !acc[i])) begin
            s_iv[i]  = ($urandom_range(0, 2) == 0);
            s_ird[i] = pick(i);
        end
        for (int p = 0; p < 2; p++) begin
            s_wen[i][p]   = (p < nwr[i]) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_wclr[i][p]  = 1'($urandom_range(0, 1));
            s_waddr[i][p] = pick(i);
            s_wdata[i][p] = {$urandom, $urandom};
            if (i == 0) s_wdata[i][p][63:32] = '0;
        end
        for (int k = 0; k < 4; k++) s_raddr[i][k] = pick(i);
    endtask

    task automatic drive();
        a_iss_valid = s_iv[0];
        a_iss_rd    = s_ird[0];
        b_iss_valid = s_iv[1];
        b_iss_rd    = s_ird[1][3:0];
        for (int p = 0; p < 2; p++) begin
            a_wr_en[p]            = s_wen[0][p];
            a_wr_clr[p]           = s_wclr[0][p];
            a_wr_addr[p*5 +: 5]   = s_waddr[0][p];
            a_wr_data[p*32 +: 32] = s_wdata[0][p][31:0];
        end
        b_wr_en[0]  = s_wen[1][0];
        b_wr_clr[0] = s_wclr[1][0];
        b_wr_addr   = s_waddr[1][0][3:0];
        b_wr_data   = s_wdata[1][0];
        for (int k = 0; k < 2; k++) a_rd_addr[k*5 +: 5] = s_raddr[0][k];
        for (int k = 0; k < 4; k++) b_rd_addr[k*4 +: 4] = s_raddr[1][k][3:0];
    endtask

    task automatic check_inst(input int i);
        logic [4:0]  ra;
        logic [63:0] ed, gd;
        logic        eb, gb;
        logic [31:0] ev, gv;
        for (int k = 0; k < nrd[i]; k++) begin
            ra = s_raddr[i][k];
            ed = m_regs[i][ra];
            eb = m_busy[i][ra];
`ifdef REGFILE_BYPASS_EN
            // Last enabled writer to this nonzero address supplies the data.
            for (int p = 0; p < nwr[i]; p++) begin
                if (s_wen[i][p] && s_waddr[i][p] == ra && ra != '0) begin
                    ed = s_wdata[i][p];
                    eb = m_busy[i][ra] && !s_wclr[i][p];
                end
            end
`endif
            gd = (i == 0) ? {32'h0, a_rd_data[k*32 +: 32]} : b_rd_data[k*64 +: 64];
            gb = (i == 0) ? a_rd_busy[k] : b_rd_busy[k];
            check($sformatf("inst%0d rd_data%0d addr %0d", i, k, ra), gd, ed);
            check($sformatf("inst%0d rd_busy%0d addr %0d", i, k, ra), 64'(gb), 64'(eb));
        end
        ev = '0;
        for (int r = 0; r < nreg[i]; r++) ev[r] = m_busy[i][r];
        gv = (i == 0) ? a_busy_vec : {16'h0, b_busy_vec};
        check($sformatf("inst%0d busy_vec", i), 64'(gv), 64'(ev));
        gb = (i == 0) ? a_iss_ready : b_iss_ready;
        eb = (s_ird[i] == '0) || !m_busy[i][s_ird[i]];
        check($sformatf("inst%0d iss_ready rd %0d", i, s_ird[i]), 64'(gb), 64'(eb));
    endtask

    task automatic commit(input int i);
        bit ok;
        ok = s_iv[i] && (s_ird[i] == '0 || !m_busy[i][s_ird[i]]);
        for (int p = 0; p < nwr[i]; p++) begin
            if (s_wen[i][p]) begin
                if (s_waddr[i][p] != '0) m_regs[i][s_waddr[i][p]] = s_wdata[i][p];
                if (s_wclr[i][p]) m_busy[i][s_waddr[i][p]] = 1'b0;
            end
        end
        if (ok && s_ird[i] != '0) m_busy[i][s_ird[i]] = 1'b1;
        acc[i] = ok;
    endtask

    initial begin
        nrd  = '{2, 4};
        nwr  = '{2, 1};
        nreg = '{32, 16};
        rst_n = 1'b0;
        a_idle();
        a_rd_addr = '0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_clr = '0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_valid = 1'b0; b_iss_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset busy_vec", 64'(a_busy_vec), 64'h0);
        check("reset iss_ready", 64'(a_iss_ready), 64'h1);
        check("reset rd_data", a_rd_data, 64'h0);

        // Write x5, then assert reset mid-cycle with a pending write to x6
        @(negedge clk);
        a_wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
        a_iss_valid = 1'b1; a_iss_rd = 5'd1;
        a_rd_addr = {5'd6, 5'd5};
        @(negedge clk);
        a_idle();
        #1;
        check("x5 written", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        check("x1 busy before reset", 64'(a_busy_vec), 64'h2);
        a_wr(0, 5'd6, 32'h1234, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset x5", 64'(a_rd_data[31:0]), 64'h0);
        check("async reset busy_vec", 64'(a_busy_vec), 64'h0);
        check("async reset iss_ready", 64'(a_iss_ready), 64'h1);
        @(negedge clk);
        a_idle();
        rst_n = 1'b1;
        #1;
        check("write under reset dropped", 64'(a_rd_data[63:32]), 64'h0);

        // Dual write to x7: port 1 wins; a write to x0 is ignored
        @(negedge clk);
        a_wr(0, 5'd7, 32'h11, 1'b0);
        a_wr(1, 5'd7, 32'h22, 1'b0);
        a_rd_addr = {5'd0, 5'd7};
        @(negedge clk);
        a_idle();
        a_wr(0, 5'd0, 32'hFFFF, 1'b0);
        #1;
        check("x7 port1 wins", 64'(a_rd_data[31:0]), 64'h22);
        @(negedge clk);
        a_idle();
        #1;
        check("x0 stays zero", 64'(a_rd_data[63:32]), 64'h0);

        // Same-cycle read of a register being written
        @(negedge clk);
        a_wr(0, 5'd9, 32'hA5A5, 1'b0);
        a_rd_addr = {5'd0, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x9 same cycle", 64'(a_rd_data[31:0]), 64'hA5A5);
`else
        check("x9 same cycle", 64'(a_rd_data[31:0]), 64'h0);
`endif
        @(negedge clk);
        a_idle();
        #1;
        check("x9 next cycle", 64'(a_rd_data[31:0]), 64'hA5A5);

        // Issue x3, refused re-issue, clear by writeback
        @(negedge clk);
        a_iss_valid = 1'b1; a_iss_rd = 5'd3;
        a_rd_addr = {5'd0, 5'd3};
        #1;
        check("x3 issue ready", 64'(a_iss_ready), 64'h1);
        @(negedge clk);
        #1;
        check("x3 rd_busy", 64'(a_rd_busy[0]), 64'h1);
        check("x3 busy_vec", 64'(a_busy_vec), 64'h8);
        check("x3 reissue refused", 64'(a_iss_ready), 64'h0);
        @(negedge clk);
        a_wr(0, 5'd3, 32'h55, 1'b1);
        #1;
        check("x3 ready ignores same-cycle clear", 64'(a_iss_ready), 64'h0);
        @(negedge clk);
        a_idle();
        a_iss_rd = 5'd3;
        #1;
        check("x3 cleared busy_vec", 64'(a_busy_vec), 64'h0);
        check("x3 ready again", 64'(a_iss_ready), 64'h1);
        check("x3 data", 64'(a_rd_data[31:0]), 64'h55);

        // Issue and clear of an idle x4 in one cycle: the set holds
        @(negedge clk);
        a_iss_valid = 1'b1; a_iss_rd = 5'd4;
        a_wr(0, 5'd4, 32'h77, 1'b1);
        a_rd_addr = {5'd0, 5'd4};
        @(negedge clk);
        a_idle();
        #1;
        check("set beats clear busy_vec", 64'(a_busy_vec), 64'h10);
        check("set beats clear data", 64'(a_rd_data[31:0]), 64'h77);
        // x4 now busy: an issue is refused, so the clear takes effect
        a_iss_valid = 1'b1; a_iss_rd = 5'd4;
        a_wr(1, 5'd4, 32'h88, 1'b1);
        @(negedge clk);
        a_idle();
        #1;
        check("refused issue then clear", 64'(a_busy_vec), 64'h0);
        check("x4 rewritten", 64'(a_rd_data[31:0]), 64'h88);

        // wr_clr without wr_en leaves the busy bit alone
        a_iss_valid = 1'b1; a_iss_rd = 5'd2;
        @(negedge clk);
        a_idle();
        a_wr_clr = 2'b01; a_wr_addr = {5'd0, 5'd2};
        @(negedge clk);
        a_idle();
        #1;
        check("clr without en", 64'(a_busy_vec), 64'h4);

        // Random phase on both instances from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[i][r] = '0;
                m_busy[i][r] = 1'b0;
            end
            s_iv[i] = 1'b0;
            acc[i]  = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            gen(0);
            gen(1);
            drive();
            #1;
            check_inst(0);
            check_inst(1);
            commit(0);
            commit(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
